uart_tx_serializer: RTL

//  Transmit stage of the UART pair: buffers bytes from the GPIO/control side in a small FIFO.

---
 rtl/uart_tx_serializer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1 UART transmitter, LSB first.
// Bit timing comes from an up-counting baud divider (0..CLKS_PER_BIT-1).
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (11-bit frame). When the macro is undefined
// the transmitter sends plain 8N1 frames.
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | even parity of the data byte (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); pulses TerminadoUart on its last edge
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clockUart,
  input  logic       resetUart,
  input  logic       StartUart,
  input  logic [7:0] info_in_Uart,
  output logic       tx_serial,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       TerminadoUart
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          done_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  logic          ovf_q;

  logic       tick;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign tick = (cnt_q == CNT_LAST);
  assign head = mem_q[rd_ptr_q];
  // Full is judged on the registered flag, so a push alongside a pop while full is still dropped.
  assign push = StartUart && !full_q;
  assign pop  = (count_q != '0) &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);
  end

  // FIFO storage, pointers, full flag and sticky overflow.
  always_ff @(posedge clockUart) begin
    if (resetUart) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= info_in_Uart;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (StartUart && full_q) ovf_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
    end
  end

  // Frame sequencer; the line level and done pulse are registered next-values.
  always_ff @(posedge clockUart) begin
    if (resetUart) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head;
`endif
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            if (pop) begin
              shift_q <= head;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^head;
`endif
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_serial     = tx_q;
  assign TerminadoUart = done_q;
  assign fifo_full     = full_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule
